// File: rtl/mac_signed_pipe.sv
// Pipelined signed multiply-accumulate: products grouped by in_first/in_last, one result per group.
// Operand register + PIPE product stages + accumulator; any stall freezes every register.
module mac_signed_pipe #(
  parameter int W1    = 8,
  parameter int W2    = 8,
  parameter int ACC_W = 24,
  parameter int PIPE  = 2,
  parameter bit SAT   = 1'b1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W1-1:0]    a,
  input  logic signed [W2-1:0]    b,
  input  logic                    in_first,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] acc,
  output logic                    out_ovf
);

  localparam int PW = W1 + W2;
  localparam int SW = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  generate
    if (ACC_W < PW) begin : g_bad_acc_w
      $fatal(1, "mac_signed_pipe: ACC_W must be at least W1+W2");
    end
    if (PIPE < 1 || PIPE > 4) begin : g_bad_pipe
      $fatal(1, "mac_signed_pipe: PIPE must lie in 1..4");
    end
  endgenerate

  logic                 stall;
  logic signed [W1-1:0] a_q;
  logic signed [W2-1:0] b_q;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] p_prod [1:PIPE];
  logic [PIPE:0]        s_vld;
  logic [PIPE:0]        s_first;
  logic [PIPE:0]        s_last;

  logic signed [ACC_W-1:0] acc_q;
  logic                    sticky_q;
  logic                    tail_vld;
  logic                    tail_first;
  logic                    tail_last;
  logic signed [SW-1:0]    base_x;
  logic signed [SW-1:0]    prod_x;
  logic signed [SW-1:0]    sum;
  logic                    sum_ovf;
  logic signed [ACC_W-1:0] res;
  logic                    res_ovf;

  assign stall    = !en || (out_valid && !out_ready);
  assign in_ready = !stall;

  assign prod = PW'(a_q) * PW'(b_q);

  // Stage 0 is the operand register; stages 1..PIPE carry the product.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s_vld <= '0;
    end else if (!stall) begin
      s_vld[0] <= in_valid;
      for (int i = 1; i <= PIPE; i++) s_vld[i] <= s_vld[i-1];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!stall) begin
      a_q        <= a;
      b_q        <= b;
      s_first[0] <= in_first;
      s_last[0]  <= in_last;
      p_prod[1]  <= prod;
      for (int i = 1; i <= PIPE; i++) begin
        s_first[i] <= s_first[i-1];
        s_last[i]  <= s_last[i-1];
      end
      for (int i = 2; i <= PIPE; i++) p_prod[i] <= p_prod[i-1];
    end
  end

  assign tail_vld   = s_vld[PIPE];
  assign tail_first = s_first[PIPE];
  assign tail_last  = s_last[PIPE];

  // One guard bit makes overflow a simple sign-bit disagreement.
  always_comb begin
    base_x  = tail_first ? '0 : {acc_q[ACC_W-1], acc_q};
    prod_x  = {{(SW-PW){p_prod[PIPE][PW-1]}}, p_prod[PIPE]};
    sum     = base_x + prod_x;
    sum_ovf = sum[SW-1] ^ sum[SW-2];
    if (sum_ovf && SAT) res = sum[SW-1] ? ACC_MIN : ACC_MAX;
    else                res = sum[ACC_W-1:0];
    res_ovf = tail_first ? sum_ovf : (sticky_q | sum_ovf);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      acc_q     <= '0;
      sticky_q  <= 1'b0;
      acc       <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      // Unstalled with out_valid high implies out_ready, so the old result has gone.
      out_valid <= tail_vld && tail_last;
      if (tail_vld) begin
        acc_q    <= res;
        sticky_q <= res_ovf;
        if (tail_last) begin
          acc     <= res;
          out_ovf <= res_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_signed_pipe.sv
// Bench for mac_signed_pipe: three configurations (24-bit sat, 16-bit sat, 16-bit wrap) share stimulus
// and are scored against a plain-arithmetic group model plus directed scenario checks.
module tb_mac_signed_pipe;

  logic sys_clk = 1'b0;
  logic sys_rst, en, in_valid, in_first, in_last, out_ready;
  logic signed [7:0] a, b;
  logic in_ready0, in_ready1, in_ready2;
  logic out_valid0, out_valid1, out_valid2;
  logic out_ovf0, out_ovf1, out_ovf2;
  logic signed [23:0] acc0;
  logic signed [15:0] acc1, acc2;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_on   = 1'b0;
  bit rand_bp  = 1'b0;

  typedef struct packed {
    logic signed [23:0] v0;
    logic signed [15:0] v1;
    logic signed [15:0] v2;
    logic [2:0]         o;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  longint macc[3];
  bit     mst[3];

  always #5 sys_clk = ~sys_clk;

  mac_signed_pipe #(.W1(8), .W2(8), .ACC_W(24), .PIPE(2), .SAT(1'b1)) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .in_first(in_first), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .acc(acc0), .out_ovf(out_ovf0));

  mac_signed_pipe #(.W1(8), .W2(8), .ACC_W(16), .PIPE(2), .SAT(1'b1)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .in_first(in_first), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .acc(acc1), .out_ovf(out_ovf1));

  mac_signed_pipe #(.W1(8), .W2(8), .ACC_W(16), .PIPE(2), .SAT(1'b0)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .in_first(in_first), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .acc(acc2), .out_ovf(out_ovf2));

  // Reference: exact integer sum, then clamp or wrap into a w-bit signed range.
  function automatic longint mstep(input longint base, input longint p, input int w,
                                   input bit sat, output bit ovf);
    longint hi, lo, span, s;
    hi   = (longint'(1) <<< (w - 1)) - 1;
    lo   = -hi - 1;
    span = longint'(1) <<< w;
    s    = base + p;
    ovf  = (s > hi) || (s < lo);
    if (!ovf) return s;
    if (sat)  return (s > hi) ? hi : lo;
    return (s > hi) ? s - span : s + span;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      macc[k] = 0;
      mst[k]  = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic model_beat(input longint p, input bit f, input bit l);
    exp_t e;
    bit   ov;
    for (int k = 0; k < 3; k++) begin
      macc[k] = mstep(f ? 64'sd0 : macc[k], p, (k == 0) ? 24 : 16, k != 2, ov);
      mst[k]  = f ? ov : (mst[k] | ov);
    end
    if (l) begin
      e.v0 = 24'(macc[0]);
      e.v1 = 16'(macc[1]);
      e.v2 = 16'(macc[2]);
      e.o  = {mst[0], mst[1], mst[2]};
      exp_q.push_back(e);
    end
  endtask

  // Inputs change just after posedge, so negedge values are what the next edge samples.
  always @(negedge sys_clk) begin
    if (mon_on && !sys_rst) begin
      n_checks++;
      if (in_ready1 !== in_ready0 || in_ready2 !== in_ready0 ||
          out_valid1 !== out_valid0 || out_valid2 !== out_valid0) begin
        n_fail++;
        $display("FAIL lockstep: in_ready=%b%b%b out_valid=%b%b%b, required all equal",
                 in_ready0, in_ready1, in_ready2, out_valid0, out_valid1, out_valid2);
      end
      if (out_valid0 && out_ready && en) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: acc=%0d with no group outstanding, required none", acc0);
        end else begin
          mon_e = exp_q.pop_front();
          if (acc0 !== mon_e.v0 || acc1 !== mon_e.v1 || acc2 !== mon_e.v2 ||
              {out_ovf0, out_ovf1, out_ovf2} !== mon_e.o) begin
            n_fail++;
            $display("FAIL result: acc=%0d/%0d/%0d ovf=%b%b%b, required acc=%0d/%0d/%0d ovf=%b",
                     acc0, acc1, acc2, out_ovf0, out_ovf1, out_ovf2,
                     mon_e.v0, mon_e.v1, mon_e.v2, mon_e.o);
          end
        end
      end
      if (in_valid && in_ready0) model_beat(longint'(a) * longint'(b), in_first, in_last);
    end
  end

  // Random backpressure and enable, active only during the random test.
  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      if (rand_bp) begin
        out_ready = ($urandom_range(0, 3) != 0);
        en        = ($urandom_range(0, 7) != 0);
      end
    end
  end

  task automatic send(input int av, input int bv, input bit f, input bit l);
    a = 8'(av); b = 8'(bv); in_first = f; in_last = l; in_valid = 1'b1;
    for (int i = 0; i <= 500; i++) begin
      @(negedge sys_clk);
      if (in_ready0) break;
      if (i == 500) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: in_ready=0 for 500 cycles, required 1");
      end
    end
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (out_valid0) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic resync();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b0;
    #2 sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    n_checks++;
    if ({out_valid0, out_valid1, out_valid2} !== 3'b000) begin
      n_fail++; $display("FAIL reset_valid: out_valid=%b%b%b, required 000", out_valid0, out_valid1, out_valid2);
    end
    n_checks++;
    if (acc0 !== 24'sd0 || acc1 !== 16'sd0 || acc2 !== 16'sd0) begin
      n_fail++; $display("FAIL reset_acc: acc=%0d/%0d/%0d, required 0", acc0, acc1, acc2);
    end
    n_checks++;
    if ({out_ovf0, out_ovf1, out_ovf2} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ovf: out_ovf=%b%b%b, required 000", out_ovf0, out_ovf1, out_ovf2);
    end
    n_checks++;
    if (in_ready0 !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: in_ready=%b, required 1", in_ready0);
    end
    resync();
    sys_rst = 1'b0;
    model_clear();
    mon_on = 1'b1;
  endtask

  task automatic test_basic_group();
    send(3, 4, 1, 0); send(-5, 6, 0, 0); send(7, -2, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge sys_clk);
      n_checks++;
      if (out_valid0 !== 1'(i == 4)) begin
        n_fail++; $display("FAIL basic_latency: cycle %0d out_valid=%b, required %b", i, out_valid0, i == 4);
      end
    end
    n_checks++;
    if (acc0 !== -24'sd32 || out_ovf0 !== 1'b0) begin
      n_fail++; $display("FAIL basic_acc: acc=%0d ovf=%b, required acc=-32 ovf=0", acc0, out_ovf0);
    end
    resync();
  endtask

  task automatic test_back_to_back();
    send(-128, -128, 1, 1); send(127, -128, 1, 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge sys_clk);
      if (i == 2) begin
        n_checks++;
        if (out_valid0 !== 1'b0) begin
          n_fail++; $display("FAIL b2b_early: out_valid=%b, required 0", out_valid0);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (out_valid0 !== 1'b1 || acc0 !== 24'sd16384) begin
          n_fail++; $display("FAIL b2b_first: valid=%b acc=%0d, required valid=1 acc=16384", out_valid0, acc0);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (out_valid0 !== 1'b1 || acc0 !== -24'sd16256) begin
          n_fail++; $display("FAIL b2b_second: valid=%b acc=%0d, required valid=1 acc=-16256", out_valid0, acc0);
        end
      end
    end
    resync();
  endtask

  task automatic test_saturation_wrap();
    bit seen;
    send(-128, -128, 1, 0); send(-128, -128, 0, 1);
    wait_out(seen);
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL satwrap_timeout: out_valid=0 after 20 cycles, required 1");
    end
    n_checks++;
    if (acc1 !== 16'sd32767 || out_ovf1 !== 1'b1) begin
      n_fail++; $display("FAIL saturate: acc=%0d ovf=%b, required acc=32767 ovf=1", acc1, out_ovf1);
    end
    n_checks++;
    if (acc2 !== 16'sh8000 || out_ovf2 !== 1'b1) begin
      n_fail++; $display("FAIL wrap: acc=%0d ovf=%b, required acc=-32768 ovf=1", acc2, out_ovf2);
    end
    n_checks++;
    if (acc0 !== 24'sd32768 || out_ovf0 !== 1'b0) begin
      n_fail++; $display("FAIL wide_no_ovf: acc=%0d ovf=%b, required acc=32768 ovf=0", acc0, out_ovf0);
    end
    resync();
    send(1, 1, 1, 1);
    wait_out(seen);
    n_checks++;
    if (!seen || acc2 !== 16'sd1 || out_ovf2 !== 1'b0) begin
      n_fail++; $display("FAIL wrap_next: valid=%b acc=%0d ovf=%b, required valid=1 acc=1 ovf=0", seen, acc2, out_ovf2);
    end
    resync();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(10, -3, 1, 0); send(-7, -9, 0, 1); send(-100, 50, 1, 1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge sys_clk);
      n_checks++;
      if (out_valid0 !== 1'(i == 3) || in_ready0 !== 1'(i != 3)) begin
        n_fail++; $display("FAIL bp_ready_drop: cycle %0d valid=%b in_ready=%b, required valid=%b in_ready=%b",
                           i, out_valid0, in_ready0, i == 3, i != 3);
      end
    end
    n_checks++;
    if (acc0 !== 24'sd33) begin
      n_fail++; $display("FAIL bp_first_acc: acc=%0d, required 33", acc0);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      n_checks++;
      if (out_valid0 !== 1'b1 || acc0 !== 24'sd33 || in_ready0 !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold: valid=%b acc=%0d in_ready=%b, required valid=1 acc=33 in_ready=0",
                           out_valid0, acc0, in_ready0);
      end
    end
    resync();
    out_ready = 1'b1;
    @(negedge sys_clk);
    n_checks++;
    if (out_valid0 !== 1'b1 || acc0 !== 24'sd33) begin
      n_fail++; $display("FAIL bp_release_a: valid=%b acc=%0d, required valid=1 acc=33", out_valid0, acc0);
    end
    @(negedge sys_clk);
    n_checks++;
    if (out_valid0 !== 1'b1 || acc0 !== -24'sd5000) begin
      n_fail++; $display("FAIL bp_release_b: valid=%b acc=%0d, required valid=1 acc=-5000", out_valid0, acc0);
    end
    @(negedge sys_clk);
    n_checks++;
    if (out_valid0 !== 1'b0) begin
      n_fail++; $display("FAIL bp_drained: valid=%b, required 0", out_valid0);
    end
    resync();
  endtask

  task automatic test_enable_stall();
    bit ready_seen;
    send(5, 6, 1, 0); send(-3, 4, 0, 0);
    en = 1'b0;
    ready_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      if (in_ready0 !== 1'b0) ready_seen = 1'b1;
    end
    n_checks++;
    if (ready_seen) begin
      n_fail++; $display("FAIL en_ready: in_ready=1 seen with en=0, required 0");
    end
    resync();
    en = 1'b1;
    send(2, -8, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge sys_clk);
      n_checks++;
      if (out_valid0 !== 1'(i == 4)) begin
        n_fail++; $display("FAIL en_mid_latency: cycle %0d out_valid=%b, required %b", i, out_valid0, i == 4);
      end
    end
    n_checks++;
    if (acc0 !== 24'sd2 || out_ovf0 !== 1'b0) begin
      n_fail++; $display("FAIL en_mid_acc: acc=%0d ovf=%b, required acc=2 ovf=0", acc0, out_ovf0);
    end
    resync();
    send(7, 7, 1, 1);
    en = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1 en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge sys_clk);
      n_checks++;
      if (out_valid0 !== 1'(i == 4)) begin
        n_fail++; $display("FAIL en_inflight_latency: cycle %0d out_valid=%b, required %b", i, out_valid0, i == 4);
      end
    end
    n_checks++;
    if (acc0 !== 24'sd49) begin
      n_fail++; $display("FAIL en_inflight_acc: acc=%0d, required 49", acc0);
    end
    resync();
  endtask

  task automatic test_reset_mid_group();
    bit seen;
    bit spurious;
    send(9, 9, 1, 0); send(1, 2, 0, 1);
    sys_rst = 1'b1;
    model_clear();
    @(negedge sys_clk);
    n_checks++;
    if (out_valid0 !== 1'b0 || acc0 !== 24'sd0) begin
      n_fail++; $display("FAIL rst_mid_clear: valid=%b acc=%0d, required valid=0 acc=0", out_valid0, acc0);
    end
    resync();
    sys_rst = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      if (out_valid0 !== 1'b0) spurious = 1'b1;
    end
    n_checks++;
    if (spurious) begin
      n_fail++; $display("FAIL rst_mid_discard: out_valid=1 after reset, required 0");
    end
    resync();
    send(2, 3, 0, 1);
    wait_out(seen);
    n_checks++;
    if (!seen || acc0 !== 24'sd6 || acc1 !== 16'sd6 || acc2 !== 16'sd6 || out_ovf0 !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_first: valid=%b acc=%0d/%0d/%0d ovf=%b, required valid=1 acc=6 ovf=0",
                         seen, acc0, acc1, acc2, out_ovf0);
    end
    resync();
  endtask

  task automatic test_random();
    int len;
    bit f0;
    int av, bv;
    rand_bp = 1'b1;
    for (int g = 0; g < 60; g++) begin
      len = $urandom_range(1, 6);
      f0  = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < len; i++) begin
        av = ($urandom_range(0, 3) == 0) ? -128 : int'($urandom_range(0, 255)) - 128;
        bv = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? -128 : 127)
                                         : int'($urandom_range(0, 255)) - 128;
        send(av, bv, (i == 0) && f0, i == len - 1);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) resync();
      end
    end
    rand_bp = 1'b0;
    @(posedge sys_clk);
    #2;
    out_ready = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clk);
      if (exp_q.size() == 0) break;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL random_drain: %0d results outstanding, required 0", exp_q.size());
    end
    resync();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst = 1'b0; en = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; a = '0; b = '0;
    model_clear();
    test_reset();
    test_basic_group();
    test_back_to_back();
    test_saturation_wrap();
    test_backpressure();
    test_enable_stall();
    test_reset_mid_group();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_signed_pipe.md
# mac_signed_pipe

Parametrised, pipelined signed multiply-accumulate unit with valid/ready handshakes on input and output. It generalises the single-shot registered signed multiplier: operand widths, accumulator width, multiply pipeline depth and overflow mode are all configurable. It accumulates a group of signed products delimited by `in_first`/`in_last`, and emits one result per group. It sits between an operand streamer (dot-product / FIR tap sequencer) and a result consumer that may apply backpressure.

## Interface
- `W1`, default 8: width of operand `a`, two's complement.
- `W2`, default 8: width of operand `b`, two's complement.
- `ACC_W`, default 24: accumulator/result width. Must be ≥ `W1+W2`; elaboration fails otherwise.
- `PIPE`, default 2: multiply pipeline stages. Legal range is 1..4.
- `SAT`, default 1: overflow mode. 1 = saturate to the `ACC_W` signed range; 0 = wrap modulo 2^`ACC_W`.

Ports:
- `sys_clk`  in  1: the single clock. All logic is rising-edge.
- `sys_rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: global advance enable. 0 freezes all state; no registers are cleared.
- `in_valid`  in  1: operand beat valid.
- `in_ready`  out  1: the unit accepts a beat.
- `a`  in  `W1`: signed multiplicand.
- `b`  in  `W2`: signed multiplier.
- `in_first`  in  1: the beat starts a new group.
- `in_last`  in  1: the beat ends the group.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: the consumer accepts the result.
- `acc`  out  `ACC_W`: signed group result.
- `out_ovf`  out  1: at least one overflow occurred within the group.

## Operation
- Handshake and stall:
  - A beat is accepted when `in_valid && in_ready`.
  - `stall = !en || (out_valid && !out_ready)`.
  - `in_ready = !stall`.
  - When stalled, every pipeline register holds, including the valid bits, `first`/`last` tags, the accumulator and the output register.
- Multiply path:
  - The product `a*b` is computed at full `W1+W2` signed width.
  - It is carried through `PIPE` registered stages with a per-stage valid bit and the `first`/`last` tags.
  - The product is sign-extended to `ACC_W + 1` bits before it is accumulated.
- Accumulate stage, when a valid product leaves the pipe:
  - `base` = 0 if `first` is set, else the accumulator.
  - `s = base + product`, computed at `ACC_W + 1` bits.
  - Overflow occurs when `s` lies outside [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - If `SAT=1`: on overflow, clamp `s` to the nearest bound.
  - If `SAT=0`: keep the low `ACC_W` bits of `s`.
  - The accumulator takes the result.
- Sticky overflow flag:
  - On a `first` beat it is set to that beat's overflow.
  - Otherwise it is ORed with that beat's overflow.
- Group completion:
  - When the product carries `last`, the same edge loads `acc` and `out_ovf` and sets `out_valid`.
  - The accumulator keeps the final value.
- A beat with both `first` and `last` set produces a single-product result.
- A beat without `first` after reset accumulates onto 0.
- `out_valid` clears on `out_valid && out_ready` unless a new `last` result loads on the same edge, in which case it stays 1 with the new data.
- Reset sets all valid bits, the accumulator, the sticky flag, `acc`, `out_ovf` and `out_valid` to 0.
  - Reset mid-group discards the group. No partial result is emitted.

## Timing
- `in_ready` is combinational from `en`, `out_valid` and `out_ready`. It never depends on `in_valid`.
- Latency: a beat accepted at edge t is in the accumulator at edge t+PIPE+1, provided no stall occurs. For a `last` beat, `out_valid` is high in the cycle after that edge.
- Each stall cycle adds exactly one cycle to the latency of every in-flight beat.
- Throughput: one beat per cycle while unstalled.
- Results appear in acceptance order. None are dropped or duplicated.
- Bubbles (`in_valid=0`) propagate as invalid stages. They do not change the accumulator.

## Test plan
- Basic group, `W1=W2=8`, `ACC_W=24`, `PIPE=2`:
  - Stimulus: beats (3,4,first), (−5,6), (7,−2,last), back-to-back.
  - Required response: `acc=−32`, `out_ovf=0`; `out_valid` rises 3 cycles after the last beat is accepted.
- Single-beat groups:
  - Stimulus: (−128,−128,first+last) then (127,−128,first+last) on consecutive cycles.
  - Required response: two results, 16384 then −16256, on consecutive cycles.
- Saturation, `ACC_W=16`, `SAT=1`:
  - Stimulus: (−128,−128,first), (−128,−128,last).
  - Required response: `acc=32767`, `out_ovf=1`.
- Wrap, `ACC_W=16`, `SAT=0`:
  - Stimulus: the same two beats.
  - Required response: `acc=−32768`, `out_ovf=1`. The next group (1,1,first+last) gives `acc=1`, `out_ovf=0`.
- Backpressure:
  - Stimulus: hold `out_ready=0` across two complete groups.
  - Required response:
    - `in_ready` drops once the first result is valid.
    - No data is lost.
    - Releasing `out_ready` delivers the results in order, one per cycle.
    - `acc` and `out_valid` stay stable while stalled.
- `en` and reset:
  - Stimulus: deassert `en` for 5 cycles mid-group.
  - Required response: the result is identical to the unstalled run.
  - Stimulus: assert `sys_rst` mid-group, then send (2,3,last) without `first`.
  - Required response: `acc=6`.
